gyro_rate_accum: RTL
====================

# gyro_rate_accum

Window accumulator downstream of the closed-loop feedback path. Sums the signed feedback step (one sample per modulation step trigger) and the thresholded error signal (one sample per error-done strobe) over a programmable number of step triggers. Pushes each completed window as a saturated 32-bit record into a small first-word-fall-through FIFO that the host register interface drains. This is the block that turns per-step feedback into the gyro rate output.

## Interface
- SUM_W, 48: internal accumulator width; must be ≥ 32 + 16.
- FIFO_DEPTH, 4: output record depth; power of two, ≥ 2.

- i_clk  in  1: system clock, DAC clock domain.
- i_rst  in  1: reset, asynchronous, active-high.
- i_en  in  1: level; 1 runs windows, 0 idles and discards any partial window.
- i_trig  in  1: one-cycle step trigger from the modulation generator.
- i_step  in  32: signed feedback step; sampled when i_trig=1.
- i_err_done  in  1: one-cycle error-ready strobe.
- i_err  in  32: signed thresholded error; sampled when i_err_done=1.
- i_win_len  in  16: triggers per window N. Value 0 is treated as 1.
- i_rd  in  1: one-cycle pop of the FIFO head.
- o_valid  out  1: FIFO not empty.
- o_rate_sum  out  32: head record, saturated Σstep.
- o_err_sum  out  32: head record, saturated Σerr.
- o_sat  out  1: head record; 1 if either sum clamped.
- o_seq  out  16: head record window sequence number, wraps at 0xFFFF→0.
- o_fifo_cnt  out  $clog2(FIFO_DEPTH)+1: occupancy.
- o_ovf_cnt  out  16: dropped windows, saturating at 0xFFFF.

## Operation
- States:
  - IDLE: accumulators, trig_cnt and the partial window are cleared.
  - ACCUM: active window.
  - LATCH: one cycle; the completed window is written to the FIFO.
- Transitions:
  - IDLE→ACCUM on i_en=1. Latch N = max(i_win_len, 1).
  - ACCUM→LATCH when i_trig=1 and trig_cnt+1 == N. That last step is included in the window.
  - LATCH→ACCUM on the next cycle. N is re-latched from i_win_len at this point.
  - Any state→IDLE when i_en=0. The partial window is discarded and nothing is pushed.
- Accumulation:
  - In ACCUM, step_acc += sign-extended i_step on i_trig.
  - err_acc += sign-extended i_err on i_err_done. Independent of i_trig; both may occur in the same cycle.
- LATCH cycle:
  - Each acc is clamped to [0x80000000, 0x7FFFFFFF].
  - sat = OR of the two clamp events.
  - Push {rate, err, sat, seq}; seq increments after every completed window, including dropped ones.
  - Accumulators restart with the value of any i_trig/i_err_done strobe arriving in the LATCH cycle, otherwise 0. No sample is lost.
  - trig_cnt restarts at 1 if i_trig fired in LATCH, otherwise 0.
- Changes to i_win_len mid-window have no effect until the next window start.
- FIFO behaviour:
  - FIFO is first-word-fall-through; head outputs are valid whenever o_valid=1.
  - Push while full and no i_rd: the record is dropped and o_ovf_cnt increments.
  - Push and i_rd in the same cycle when full: pop and push both succeed.
  - i_rd while empty: ignored.
- i_en=0 does not flush the FIFO.

## Timing
- Reset: state IDLE; accumulators, trig_cnt and seq are 0. All outputs are 0, including o_valid, o_fifo_cnt and o_ovf_cnt.
- Latency: final i_trig at edge t → LATCH at t+1 → record written at the end of t+1 → o_valid/o_fifo_cnt updated at t+2.
- Pop: i_rd at edge t → next head (or o_valid=0) visible at t+1.
- Minimum spacing between i_trig pulses is 2 cycles. No back-to-back window completions are possible with N=1.
- Throughput: one window per N triggers. The FIFO absorbs host read latency of up to FIFO_DEPTH windows.

## Structure
- Shared package gyro_pkg:
  - record struct {rate[31:0], err[31:0], sat, seq[15:0]};
  - clamp constants S32_MAX/S32_MIN;
  - state enum {IDLE, ACCUM, LATCH}.
- Sub-module sync_fifo_fwft (params WIDTH, DEPTH): same-cycle push/pop, full/empty, count. Reusable by other host-readout blocks.
- Top: FSM, two SUM_W accumulators, trig counter, clamp logic, seq counter, ovf counter.

## Test plan
- Basic window: N=4, i_en=1, steps 10, −3, 7, 1 on four triggers; i_err_done with 5, 5 → one record, rate=15, err=10, sat=0, seq=0; o_valid rises 2 cycles after the 4th trigger.
- Saturation and N=0: i_win_len=0, single step 0x7FFFFFFF → rate=0x7FFFFFFF, sat=0. N=2 with two steps 0x7FFFFFFF → rate=0x7FFFFFFF, sat=1. N=2 with two steps 0x80000000 → rate=0x80000000, sat=1.
- Boundary strobes: i_trig and i_err_done in the LATCH cycle with step=9, err=4 → the next window includes 9 and 4; trig_cnt starts at 1, so with N=3 only 2 further triggers close it.
- Overflow: N=1, no reads, 6 windows → o_fifo_cnt=4, o_ovf_cnt=2, stored seq 0..3. Then a push and i_rd in the same cycle while full → cnt stays 4, ovf unchanged.
- Disable/reset mid-window: 2 of 4 triggers, then i_en=0 → no push, FIFO intact. Re-enable → fresh window. Assert i_rst mid-ACCUM → all outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/gyro_pkg.sv
// Shared types and constants for the gyro rate accumulation path.
package gyro_pkg;

    localparam int unsigned REC_W = 32 + 32 + 1 + 16;

    localparam logic signed [31:0] S32_MAX = 32'sh7FFF_FFFF;
    localparam logic signed [31:0] S32_MIN = 32'sh8000_0000;

    typedef struct packed {
        logic [31:0] rate;
        logic [31:0] err;
        logic        sat;
        logic [15:0] seq;
    } rec_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        LATCH = 2'd2
    } state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; head word is always presented on dout.
module sync_fifo_fwft #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/gyro_rate_accum.sv
// Windowed sum of feedback steps and thresholded error; each finished window is
// clamped to 32 bits and queued for the host as one rate record.
module gyro_rate_accum
    import gyro_pkg::*;
#(
    parameter int unsigned SUM_W      = 48,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_en,
    input  logic                          i_trig,
    input  logic [31:0]                   i_step,
    input  logic                          i_err_done,
    input  logic [31:0]                   i_err,
    input  logic [15:0]                   i_win_len,
    input  logic                          i_rd,
    output logic                          o_valid,
    output logic [31:0]                   o_rate_sum,
    output logic [31:0]                   o_err_sum,
    output logic                          o_sat,
    output logic [15:0]                   o_seq,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_cnt,
    output logic [15:0]                   o_ovf_cnt
);

    localparam logic signed [SUM_W-1:0] ACC_MAX = SUM_W'(S32_MAX);
    localparam logic signed [SUM_W-1:0] ACC_MIN = SUM_W'(S32_MIN);

    state_t                  state;
    logic [15:0]             win_n;
    logic [15:0]             trig_cnt;
    logic [15:0]             seq;
    logic signed [SUM_W-1:0] step_acc;
    logic signed [SUM_W-1:0] err_acc;

    logic signed [SUM_W-1:0] step_in;
    logic signed [SUM_W-1:0] err_in;
    logic [15:0]             win_len_eff;
    logic                    win_done;
    logic                    rate_hi, rate_lo, err_hi, err_lo;
    logic                    push;
    logic                    fifo_full;
    logic                    fifo_empty;
    rec_t                    rec;
    rec_t                    head;

    // Sample selection, window-close detect and 32-bit clamp of the finished sums.
    always_comb begin
        step_in     = i_trig     ? SUM_W'($signed(i_step)) : '0;
        err_in      = i_err_done ? SUM_W'($signed(i_err))  : '0;
        win_len_eff = (i_win_len == 16'd0) ? 16'd1 : i_win_len;
        win_done    = i_trig && ((17'(trig_cnt) + 17'd1) >= 17'(win_n));

        rate_hi  = step_acc > ACC_MAX;
        rate_lo  = step_acc < ACC_MIN;
        err_hi   = err_acc  > ACC_MAX;
        err_lo   = err_acc  < ACC_MIN;

        rec.rate = rate_hi ? S32_MAX : (rate_lo ? S32_MIN : step_acc[31:0]);
        rec.err  = err_hi  ? S32_MAX : (err_lo  ? S32_MIN : err_acc[31:0]);
        rec.sat  = rate_hi | rate_lo | err_hi | err_lo;
        rec.seq  = seq;

        push     = (state == LATCH) && i_en;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            win_n     <= 16'd1;
            trig_cnt  <= '0;
            step_acc  <= '0;
            err_acc   <= '0;
            seq       <= '0;
            o_ovf_cnt <= '0;
        end else begin
            if (push) begin
                seq <= seq + 16'd1;
            end
            if (push && fifo_full && !i_rd && (o_ovf_cnt != 16'hFFFF)) begin
                o_ovf_cnt <= o_ovf_cnt + 16'd1;
            end

            if (!i_en) begin
                state    <= IDLE;
                trig_cnt <= '0;
                step_acc <= '0;
                err_acc  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state    <= ACCUM;
                        win_n    <= win_len_eff;
                        trig_cnt <= '0;
                        step_acc <= '0;
                        err_acc  <= '0;
                    end
                    ACCUM: begin
                        step_acc <= step_acc + step_in;
                        err_acc  <= err_acc + err_in;
                        if (win_done) begin
                            state <= LATCH;
                        end else if (i_trig) begin
                            trig_cnt <= trig_cnt + 16'd1;
                        end
                    end
                    LATCH: begin
                        // Strobes landing here open the next window so no sample is lost.
                        state    <= ACCUM;
                        win_n    <= win_len_eff;
                        step_acc <= step_in;
                        err_acc  <= err_in;
                        trig_cnt <= {15'd0, i_trig};
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    sync_fifo_fwft #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (push),
        .pop   (i_rd),
        .din   (rec),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (o_fifo_cnt)
    );

    assign o_valid    = !fifo_empty;
    assign o_rate_sum = head.rate;
    assign o_err_sum  = head.err;
    assign o_sat      = head.sat;
    assign o_seq      = head.seq;

endmodule
